// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage of the ARM-subset pipelined core.
// Contents: default reset PC, NOP encoding, instruction width and the
// fetch-control state type.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program-counter register with next-value selection.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, loads RESET_PC
//   load_i    1 = update the PC on this edge
//   branch_i  1 = next PC is target_i (word aligned), 0 = pc + 4
//   target_i  branch target byte address
//   pc_o      registered program counter
module fetch_stage_pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        branch_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Low target bits are dropped so the PC is always word aligned.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^target_i[1:0];

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (branch_i) pc_d = {target_i[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc_q <= RESET_PC;
    else if (load_i) pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   le            load enable from hazard unit (0 = stall)
//   br_taken      branch resolved taken in decode this cycle
//   br_target     branch target byte address
//   imem_data     instruction word read combinationally at imem_addr
//   imem_addr     truncated PC to instruction memory
//   pc            current fetch PC
//   id_instr      IF/ID instruction (NOP for bubbles)
//   id_pc         PC of id_instr
//   id_valid      1 = id_instr is a real fetched instruction
//   fetch_count   instructions accepted into IF/ID since reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               le,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  input  logic [31:0]        imem_data,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic               id_valid,
  output logic [15:0]        fetch_count
);

  fetch_state_e state_q, state_d;

  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [15:0]        count_q, count_d;
  logic               pc_load, pc_branch;
  logic [31:0]        pc_cur;

  fetch_stage_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_i   (pc_load),
    .branch_i (pc_branch),
    .target_i (br_target),
    .pc_o     (pc_cur)
  );

  always_comb begin
    state_d    = state_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    count_d    = count_q;
    pc_load    = 1'b0;
    pc_branch  = 1'b0;

    if (state_q == BOOT) begin
      // PC still holds RESET_PC here, so pc + 4 gives RESET_PC + 4.
      state_d    = RUN;
      pc_load    = 1'b1;
      id_instr_d = imem_data;
      id_pc_d    = RESET_PC;
      id_valid_d = 1'b1;
      count_d    = 16'd1;
    end else if (br_taken) begin
      // Redirect overrides a stall; the wrong-path slot becomes a bubble.
      pc_load    = 1'b1;
      pc_branch  = 1'b1;
      id_instr_d = NOP_INSTR;
      id_pc_d    = '0;
      id_valid_d = 1'b0;
    end else if (le) begin
      pc_load    = 1'b1;
      id_instr_d = imem_data;
      id_pc_d    = pc_cur;
      id_valid_d = 1'b1;
      count_d    = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_cur[IMEM_AW-1:0];
  assign pc          = pc_cur;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        le;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_data;
  logic [7:0]  imem_addr;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state: what the fetch stage should present.
  bit          m_boot;
  logic [31:0] m_pc, m_instr, m_idpc;
  logic        m_valid;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(
    .RESET_PC (RST_PC),
    .IMEM_AW  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .le          (le),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[7:0];
    return mem[idx];
  endfunction

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = RST_PC;
    m_instr = 32'h0;
    m_idpc  = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 16'h0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       pc,                  m_pc);
    chk({tag, ".addr"},     {24'h0, imem_addr},  {24'h0, m_pc[7:0]});
    chk({tag, ".instr"},    id_instr,            m_instr);
    chk({tag, ".idpc"},     id_pc,               m_idpc);
    chk({tag, ".valid"},    {31'h0, id_valid},   {31'h0, m_valid});
    chk({tag, ".count"},    {16'h0, fetch_count},{16'h0, m_cnt});
  endtask

  // One clock edge: model consumes the inputs held across the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (m_boot) begin
      m_instr = mem_at(RST_PC);
      m_idpc  = RST_PC;
      m_pc    = RST_PC + 32'd4;
      m_valid = 1'b1;
      m_cnt   = 16'd1;
      m_boot  = 1'b0;
    end else if (br_taken) begin
      m_pc    = br_target & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_idpc  = 32'h0;
      m_valid = 1'b0;
    end else if (le) begin
      m_instr = mem_at(m_pc);
      m_idpc  = m_pc;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
    end
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges, checks reset values before the next edge.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    model_reset();
    #1 check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hE000_0000 | i;
    reset = 1'b1; le = 1'b1; br_taken = 1'b0; br_target = '0;
    model_reset();
    #1 check_all("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all("rst_hold");

    // Free running: BOOT then three normal fetches.
    for (int i = 0; i < 4; i++) step("run");
    chk("run4.idpc",  id_pc, 32'd12);
    chk("run4.instr", id_instr, 32'hE000_000C);
    chk("run4.count", {16'h0, fetch_count}, 32'd4);

    // Stall for three cycles: everything frozen.
    le = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.pc", pc, 32'd16);
    le = 1'b1;
    step("resume");
    chk("resume.idpc", id_pc, 32'd16);

    // Branch to 0x40: one bubble, then target instruction.
    br_taken = 1'b1; br_target = 32'h40;
    step("br");
    chk("br.pc", pc, 32'h40);
    chk("br.valid", {31'h0, id_valid}, 32'd0);
    br_taken = 1'b0;
    step("br_tgt");
    chk("br_tgt.idpc", id_pc, 32'h40);
    chk("br_tgt.count", {16'h0, fetch_count}, 32'd6);

    // Branch during stall with unaligned target.
    le = 1'b0; br_taken = 1'b1; br_target = 32'h83;
    step("brstall");
    chk("brstall.pc", pc, 32'h80);
    br_taken = 1'b0;
    step("brstall_hold");
    le = 1'b1;

    // PC wrap at the top of the address space.
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step("brwrap");
    br_taken = 1'b0;
    step("wrap");
    chk("wrap.idpc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc", pc, 32'h0);

    // Async reset while stalled, then BOOT again.
    le = 1'b0;
    step("prestall");
    async_reset("midrst");
    step("reboot");
    chk("reboot.idpc", id_pc, RST_PC);
    chk("reboot.valid", {31'h0, id_valid}, 32'd1);

    // Randomized traffic with random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      le        = ($urandom_range(3) != 0);
      br_taken  = ($urandom_range(7) == 0);
      br_target = ($urandom_range(3) == 0) ? $urandom : {24'h0, 8'($urandom)};
      if ($urandom_range(299) == 0) async_reset("rnd_rst");
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
